// File: rtl/risac_lsu.sv
// rtl/risac_lsu.sv - RISAC load/store unit bridging the core data port to a 1024x32 Avalon-style memory.
// Optional RISAC_LSU_STATS_EN adds ld_count/st_count counters of completed error-free accesses.
module risac_lsu #(
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata
`ifdef RISAC_LSU_STATS_EN
    ,
    output logic [31:0]       ld_count,
    output logic [31:0]       st_count
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    logic [1:0]          r_lane;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic                r_we;
    logic [1:0]          r_cnt;
    logic                r_cs;
    logic                r_write;
    logic [3:0]          r_be;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_resp_valid;
    logic [31:0]         r_resp_rdata;
    logic                r_resp_err;
`ifdef RISAC_LSU_STATS_EN
    logic [31:0]         r_ld_count;
    logic [31:0]         r_st_count;
`endif

    logic                w_err;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    logic [31:0]         w_shift;
    logic [31:0]         w_load;

    // The request is checked in the accept cycle so errors never reach memory.
    assign w_err = (req_size == 2'b11)
                || (req_size == 2'b01 && req_addr[0])
                || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                || (req_addr[31:ADDR_W+2] != '0);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
        case (req_size)
            2'b00: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << req_addr[1:0];
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_shift = mem_readdata >> {r_lane, 3'b000};

    always_comb begin
        w_load = w_shift;
        case (r_size)
            2'b00:   w_load = r_unsigned ? {24'h0, w_shift[7:0]}
                                         : {{24{w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_load = r_unsigned ? {16'h0, w_shift[15:0]}
                                         : {{16{w_shift[15]}}, w_shift[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_lane       <= '0;
            r_size       <= '0;
            r_unsigned   <= 1'b0;
            r_we         <= 1'b0;
            r_cnt        <= '0;
            r_cs         <= 1'b0;
            r_write      <= 1'b0;
            r_be         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
`ifdef RISAC_LSU_STATS_EN
            r_ld_count   <= '0;
            r_st_count   <= '0;
`endif
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (req_valid) begin
                        r_lane     <= req_addr[1:0];
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_we       <= req_we;
                        if (w_err) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= '0;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state <= S_ACCESS;
                            r_cs    <= 1'b1;
                            r_write <= req_we;
                            r_be    <= w_be;
                            r_addr  <= req_addr[ADDR_W+1:2];
                            r_wdata <= w_wdata;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    r_cs    <= 1'b0;
                    r_write <= 1'b0;
                    r_be    <= '0;
                    if (r_we) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= '0;
                        r_resp_err   <= 1'b0;
`ifdef RISAC_LSU_STATS_EN
                        r_st_count   <= r_st_count + 32'd1;
`endif
                    end else begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 2'(READ_LATENCY - 1)) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_load;
                        r_resp_err   <= 1'b0;
`ifdef RISAC_LSU_STATS_EN
                        r_ld_count   <= r_ld_count + 32'd1;
`endif
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready      = (r_state == S_IDLE) || (r_state == S_RESP);
    assign resp_valid     = r_resp_valid;
    assign resp_rdata     = r_resp_rdata;
    assign resp_err       = r_resp_err;
    assign mem_address    = r_addr;
    assign mem_byteenable = r_be;
    assign mem_chipselect = r_cs;
    assign mem_write      = r_write;
    assign mem_writedata  = r_wdata;
`ifdef RISAC_LSU_STATS_EN
    assign ld_count       = r_ld_count;
    assign st_count       = r_st_count;
`endif

endmodule

// File: tb/tb_risac_lsu.sv
// tb/tb_risac_lsu.sv - Self-checking bench for risac_lsu against a byte-addressed reference memory.
module tb_risac_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, req_valid, sel, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        valid_d [2];
    logic        ready_d [2];
    logic        rv_d    [2];
    logic        err_d   [2];
    logic        cs_d    [2];
    logic        wr_d    [2];
    logic [31:0] rdata_d [2];
    logic [31:0] wd_d    [2];
    logic [31:0] rd_d    [2];
    logic [9:0]  addr_d  [2];
    logic [3:0]  be_d    [2];
    logic [31:0] ldc_d   [2];
    logic [31:0] stc_d   [2];

    assign valid_d[0] = req_valid && !sel;
    assign valid_d[1] = req_valid && sel;

    risac_lsu #(.ADDR_W(10), .READ_LATENCY(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .req_valid(valid_d[0]), .req_ready(ready_d[0]),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv_d[0]),
        .resp_rdata(rdata_d[0]), .resp_err(err_d[0]), .mem_address(addr_d[0]),
        .mem_byteenable(be_d[0]), .mem_chipselect(cs_d[0]), .mem_write(wr_d[0]),
        .mem_writedata(wd_d[0]), .mem_readdata(rd_d[0])
`ifdef RISAC_LSU_STATS_EN
        , .ld_count(ldc_d[0]), .st_count(stc_d[0])
`endif
    );

    risac_lsu #(.ADDR_W(10), .READ_LATENCY(3)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .req_valid(valid_d[1]), .req_ready(ready_d[1]),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv_d[1]),
        .resp_rdata(rdata_d[1]), .resp_err(err_d[1]), .mem_address(addr_d[1]),
        .mem_byteenable(be_d[1]), .mem_chipselect(cs_d[1]), .mem_write(wr_d[1]),
        .mem_writedata(wd_d[1]), .mem_readdata(rd_d[1])
`ifdef RISAC_LSU_STATS_EN
        , .ld_count(ldc_d[1]), .st_count(stc_d[1])
`endif
    );

`ifndef RISAC_LSU_STATS_EN
    assign ldc_d[0] = '0;
    assign ldc_d[1] = '0;
    assign stc_d[0] = '0;
    assign stc_d[1] = '0;
`endif

    // Memory slaves: read data appears READ_LATENCY edges after the sampling edge.
    logic [31:0] mem  [2][1024];
    logic [31:0] pipe [2][3];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            pipe[k][2] <= pipe[k][1];
            pipe[k][1] <= pipe[k][0];
            pipe[k][0] <= (cs_d[k] && !wr_d[k]) ? mem[k][addr_d[k]] : 32'h0;
            if (cs_d[k] && wr_d[k])
                for (int b = 0; b < 4; b++)
                    if (be_d[k][b]) mem[k][addr_d[k]][8*b +: 8] = wd_d[k][8*b +: 8];
        end
    end
    assign rd_d[0] = pipe[0][0];
    assign rd_d[1] = pipe[1][2];

    logic [7:0]  ref_mem [4096];
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp_ld = 0, exp_st = 0;
    logic [3:0]  last_be;
    logic [31:0] last_wd, last_rdata, last_st;
    int          last_lat;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic ref_err(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || (size == 2'd1 && addr[0]) ||
               (size == 2'd2 && addr[1:0] != 2'd0) || (addr >= 32'h1000);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr);
        int n;
        logic [31:0] v;
        n = 1 << size;
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[12'(addr + 32'(i))]) << (8*i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] be;
        be = 4'h0;
        for (int i = 0; i < (1 << size); i++) be[2'(addr + 32'(i))] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] ref_wd(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] v;
        int n;
        n = 1 << size;
        for (int l = 0; l < 4; l++) v[8*l +: 8] = wdata[8*(l % n) +: 8];
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input int widx);
        return {ref_mem[4*widx+3], ref_mem[4*widx+2], ref_mem[4*widx+1], ref_mem[4*widx]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic run_req(input int k, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        logic e, any_cs, c1_cs, c1_wr, g_err;
        logic [3:0] c1_be;
        logic [9:0] c1_addr;
        logic [31:0] c1_wd, g_rd, exp_rd, g_ld, g_st;
        int exp_lat, got_lat;
        e       = ref_err(size, addr);
        exp_lat = e ? 1 : (we ? 2 : 2 + lat(k));
        exp_rd  = (e || we) ? 32'h0 : ref_load(size, uns, addr);
        @(negedge clk);
        sel = (k != 0); req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        check("req_ready", 32'(ready_d[k]), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        got_lat = 0; any_cs = 1'b0; g_rd = 'x; g_err = 1'bx; g_ld = 'x; g_st = 'x;
        c1_cs = 1'b0; c1_wr = 1'b0; c1_be = 'x; c1_addr = 'x; c1_wd = 'x;
        for (int c = 1; c <= 10; c++) begin
            if (c == 1) begin
                c1_cs = cs_d[k]; c1_wr = wr_d[k]; c1_be = be_d[k];
                c1_addr = addr_d[k]; c1_wd = wd_d[k];
            end
            any_cs = any_cs | cs_d[k];
            if (rv_d[k]) begin
                got_lat = c; g_rd = rdata_d[k]; g_err = err_d[k];
                g_ld = ldc_d[k]; g_st = stc_d[k];
                break;
            end
            @(negedge clk);
        end
        check("latency", 32'(got_lat), 32'(exp_lat));
        check("resp_err", 32'(g_err), 32'(e));
        check("resp_rdata", g_rd, exp_rd);
        if (e) begin
            check("err_no_cs", 32'(any_cs), 32'd0);
        end else begin
            check("c1_cs", 32'(c1_cs), 32'd1);
            check("c1_write", 32'(c1_wr), 32'(we));
            check("c1_be", 32'(c1_be), 32'(ref_be(size, addr)));
            check("c1_addr", 32'(c1_addr), 32'(addr[11:2]));
            if (we) check("c1_wdata", c1_wd, ref_wd(size, wdata));
            if (we) for (int i = 0; i < (1 << size); i++)
                ref_mem[12'(addr + 32'(i))] = wdata[8*i +: 8];
        end
`ifdef RISAC_LSU_STATS_EN
        if (k == 0) begin
            if (!e && we) exp_st = exp_st + 32'd1;
            if (!e && !we) exp_ld = exp_ld + 32'd1;
            check("st_count", g_st, exp_st);
            check("ld_count", g_ld, exp_ld);
        end
`endif
        last_be = c1_be; last_wd = c1_wd; last_rdata = g_rd; last_lat = got_lat; last_st = g_st;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v, a, b2b_exp [4];
        logic [1:0]  sz;
        int          b2b_cyc [4], idx, nresp, nrv;

        reset_n = 1'b0; req_valid = 1'b0; sel = 1'b0; req_we = 1'b0;
        req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int w = 0; w < 1024; w++) begin
            v = $urandom;
            mem[0][w] = v; mem[1][w] = v;
            for (int i = 0; i < 4; i++) ref_mem[4*w+i] = v[8*i +: 8];
        end
        repeat (3) @(negedge clk);
        check("rst_resp_valid", 32'(rv_d[0]), 32'd0);
        check("rst_resp_rdata", rdata_d[0], 32'd0);
        check("rst_resp_err", 32'(err_d[0]), 32'd0);
        check("rst_cs", 32'(cs_d[0]), 32'd0);
        check("rst_write", 32'(wr_d[0]), 32'd0);
        check("rst_be", 32'(be_d[0]), 32'd0);
        check("rst_addr", 32'(addr_d[0]), 32'd0);
        check("rst_wdata", wd_d[0], 32'd0);
        check("rst_ready", 32'(ready_d[0]), 32'd1);
        check("rst_ld_count", ldc_d[0], 32'd0);
        reset_n = 1'b1;

        run_req(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        check("sw_be", 32'(last_be), 32'hF);
        run_req(0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h123456A5);
        check("sb_be", 32'(last_be), 32'h8);
        check("sb_wdata", last_wd, 32'hA5A5A5A5);
        run_req(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        check("lb_signed", last_rdata, 32'hFFFFFFA5);
        run_req(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        check("lb_unsigned", last_rdata, 32'h000000A5);

        for (int k = 0; k < 2; k++) begin
            mem[0][4] = 32'h8001BEEF; mem[1][4] = 32'h8001BEEF;
            ref_mem[16] = 8'hEF; ref_mem[17] = 8'hBE; ref_mem[18] = 8'h01; ref_mem[19] = 8'h80;
            run_req(k, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
            check("lh_rdata", last_rdata, 32'hFFFF8001);
            check("lh_be", 32'(last_be), 32'hC);
            check("lh_latency", 32'(last_lat), 32'(2 + lat(k)));
        end

        run_req(0, 1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
        run_req(0, 1'b0, 2'd2, 1'b0, 32'h1E, 32'h0);
        run_req(0, 1'b1, 2'd3, 1'b0, 32'h10, 32'h0);
        run_req(0, 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
        check("err_window", 32'(last_lat), 32'd1);

        // Back-to-back loads with req_valid held high throughout.
        for (int i = 0; i < 4; i++) b2b_exp[i] = ref_load(2'd2, 1'b0, 32'(4 * (8 + 3*i)));
        idx = 0; nresp = 0;
        @(negedge clk);
        sel = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (rv_d[0]) begin
                if (nresp < 4) begin
                    check("b2b_rdata", rdata_d[0], b2b_exp[nresp]);
                    b2b_cyc[nresp] = c;
                end
                nresp++;
            end
            if (ready_d[0]) begin
                if (idx < 4) begin
                    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
                    req_addr = 32'(4 * (8 + 3*idx)); req_valid = 1'b1;
                    idx++;
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (nresp >= 4) break;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_count", 32'(nresp), 32'd4);
        for (int i = 0; i < 4; i++) check("b2b_cycle", 32'(b2b_cyc[i]), 32'(3 * (i + 1)));
        exp_ld = exp_ld + 32'd4;

        for (int i = 0; i < 60; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 2) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            run_req(0, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        // Reset asserted during the ACCESS cycle of a store.
        @(negedge clk);
        sel = 1'b0; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h40;
        req_wdata = ~ref_word(16); req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("rst_mid_write_pre", 32'(wr_d[0]), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_write", 32'(wr_d[0]), 32'd0);
        check("rst_mid_cs", 32'(cs_d[0]), 32'd0);
        nrv = 0;
        repeat (2) begin
            @(negedge clk);
            nrv += int'(rv_d[0]);
        end
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            nrv += int'(rv_d[0]);
        end
        check("rst_mid_no_resp", 32'(nrv), 32'd0);
        check("rst_mid_mem", mem[0][16], ref_word(16));
        exp_ld = 0; exp_st = 0;

`ifdef RISAC_LSU_STATS_EN
        @(negedge clk);
        force u_dut_a.r_st_count = 32'hFFFFFFFF;
        @(negedge clk);
        release u_dut_a.r_st_count;
        exp_st = 32'hFFFFFFFF;
        run_req(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h01020304);
        check("st_wrap", last_st, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
